// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage registered delay line with a valid tag per
// stage, clock enable, synchronous clear, a combinational tap selector and a
// registered count of how many stages currently hold valid data.
// With DEPTH=1, WIDTH=1, EN=1, DV=1, CLR=0 the Q output is a plain D flip-flop.
module dff_pipe #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int unsigned      TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned      CW        = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    input  logic [TW-1:0]    TAP_SEL,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic [WIDTH-1:0] TAP,
    output logic             TAPV,
    output logic [CW-1:0]    FILL
);

    // Flattened view of every stage, index 0 is the newest entry.
    logic [DEPTH-1:0][WIDTH-1:0] stage_data;
    logic [DEPTH-1:0]            stage_valid;

    // Occupancy counter, kept in step with the valid tags.
    logic [CW-1:0]               fill_reg;
    logic [CW-1:0]               fill_next;

    // Tap mux result.
    logic [WIDTH-1:0]            tap_data;
    logic                        tap_valid;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;
            logic [WIDTH-1:0] src_data;
            logic             src_valid;

            // Stage 0 loads from the ports; every later stage loads from
            // its predecessor, so the whole line advances together.
            if (gi == 0) begin : g_head
                assign src_data  = D;
                assign src_valid = DV;
            end else begin : g_body
                assign src_data  = stage_data[gi-1];
                assign src_valid = stage_valid[gi-1];
            end

            // One pipeline stage: clear beats enable; data moves even when
            // the valid tag is 0, because the tag only qualifies the word.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    data_reg  <= RESET_VAL;
                    valid_reg <= 1'b0;
                end else if (CLR) begin
                    data_reg  <= RESET_VAL;
                    valid_reg <= 1'b0;
                end else if (EN) begin
                    data_reg  <= src_data;
                    valid_reg <= src_valid;
                end
            end

            assign stage_data[gi]  = data_reg;
            assign stage_valid[gi] = valid_reg;
        end
    endgenerate

    // Occupancy follows what enters stage 0 and what leaves the last stage;
    // a word entering while another leaves leaves the count unchanged.
    always_comb begin
        fill_next = fill_reg;
        if (CLR) begin
            fill_next = '0;
        end else if (EN) begin
            case ({DV, stage_valid[DEPTH-1]})
                2'b10:   fill_next = fill_reg + CW'(1);
                2'b01:   fill_next = fill_reg - CW'(1);
                default: fill_next = fill_reg;
            endcase
        end
    end

    // Occupancy register, cleared together with the valid tags.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fill_reg <= '0;
        end else begin
            fill_reg <= fill_next;
        end
    end

    // Tap selection; out-of-range selects fall back to the last stage, which
    // also makes the selector a don't-care when there is only one stage.
    always_comb begin
        tap_data  = stage_data[DEPTH-1];
        tap_valid = stage_valid[DEPTH-1];
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (int'(TAP_SEL) == k) begin
                tap_data  = stage_data[k];
                tap_valid = stage_valid[k];
            end
        end
    end

    assign Q    = stage_data[DEPTH-1];
    assign QV   = stage_valid[DEPTH-1];
    assign TAP  = tap_data;
    assign TAPV = tap_valid;
    assign FILL = fill_reg;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: scoreboard of expected Q/QV words plus a
// queue-based picture of the pipeline for FILL and TAP, directed scenarios,
// randomized traffic, and a DEPTH=1/WIDTH=1 flip-flop equivalence run.
`timescale 1ns/10ps
module tb_dff_pipe;

    localparam int        N  = 4;
    localparam logic [7:0] RV = 8'h00;

    // Main DUT (WIDTH=8, DEPTH=4)
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] d = 8'h00;
    logic [1:0] tap_sel = 2'd0;
    logic [7:0] q, tap;
    logic       qv, tapv;
    logic [2:0] fill;

    // DEPTH=3 DUT sharing the main stimulus
    logic [1:0] tap_sel3 = 2'd0;
    logic [7:0] q3, tap3;
    logic       qv3, tapv3;
    logic [1:0] fill3;

    // Legacy DUT (WIDTH=1, DEPTH=1)
    logic       clk1 = 1'b0;
    logic       rstn1 = 1'b0;
    logic       d1 = 1'b0;
    logic       en1 = 1'b1;
    logic       clr1 = 1'b0;
    logic       dv1 = 1'b1;
    logic       tap_sel1 = 1'b0;
    logic       q1, qv1, tap1, tapv1;
    logic       fill1;
    logic       sq;

    int n_pass = 0;
    int n_total = 0;

    // Scoreboard of {data, valid} words still to appear at Q.
    logic [8:0] exp_q[$];

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) dut (
        .CLK(clk), .RSTN(rstn), .EN(en), .CLR(clr), .D(d), .DV(dv),
        .TAP_SEL(tap_sel), .Q(q), .QV(qv), .TAP(tap), .TAPV(tapv), .FILL(fill)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV)) dut3 (
        .CLK(clk), .RSTN(rstn), .EN(en), .CLR(clr), .D(d), .DV(dv),
        .TAP_SEL(tap_sel3), .Q(q3), .QV(qv3), .TAP(tap3), .TAPV(tapv3), .FILL(fill3)
    );

    dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut1 (
        .CLK(clk1), .RSTN(rstn1), .EN(en1), .CLR(clr1), .D(d1), .DV(dv1),
        .TAP_SEL(tap_sel1), .Q(q1), .QV(qv1), .TAP(tap1), .TAPV(tapv1), .FILL(fill1)
    );

    always #5 clk = ~clk;

    initial begin
        #0.5;
        forever #4 clk1 = ~clk1;
    end

    // Reference for the legacy dff: sq <= D.
    always @(posedge clk1 or negedge rstn1) begin
        if (!rstn1) sq <= 1'b0;
        else        sq <= d1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // After reset/clear the first DEPTH-1 words seen at Q are reset contents.
    task automatic sb_reset();
        exp_q.delete();
        repeat (N - 1) exp_q.push_back({RV, 1'b0});
    endtask

    task automatic drive(input logic e, input logic c, input logic [7:0] dd,
                         input logic vv, input logic [1:0] ts);
        @(negedge clk);
        en = e; clr = c; d = dd; dv = vv; tap_sel = ts;
        if (c) sb_reset();
        else if (e) exp_q.push_back({dd, vv});
        $display("txn en=%0b clr=%0b d=%02h dv=%0b tap_sel=%0d", e, c, dd, vv, ts);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        sb_reset();
        #1;
        chk("rst_q", q, RV);
        chk("rst_qv", qv, 0);
        chk("rst_fill", fill, 0);
        chk("rst_tap", tap, RV);
        chk("rst_tapv", tapv, 0);
        chk("rst3_fill", fill3, 0);
        @(negedge clk);
        chk("rst_hold_q", q, RV);
        chk("rst_hold_fill", fill, 0);
        en = 1'b0; clr = 1'b0; rstn = 1'b1;
        $display("txn async reset pulse");
    endtask

    // Monitor: pop the scoreboard on every enabled edge and compare Q/QV
    // every cycle; FILL and TAP come from a newest-first list of stages.
    initial begin : monitor
        logic       s_rst, s_en, s_clr, s_dv;
        logic [7:0] s_d;
        logic [8:0] cur, h;
        logic [8:0] hist[$];
        int         fcnt, sel;
        cur = {RV, 1'b0};
        for (int k = 0; k < N; k++) hist.push_back({RV, 1'b0});
        forever begin
            @(posedge clk);
            s_rst = rstn; s_en = en; s_clr = clr; s_d = d; s_dv = dv;
            #2;
            if (!s_rst || s_clr) begin
                cur = {RV, 1'b0};
                hist.delete();
                for (int k = 0; k < N; k++) hist.push_back({RV, 1'b0});
            end else if (s_en) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: got empty scoreboard, expected a word");
                end else begin
                    cur = exp_q.pop_front();
                end
                hist.push_front({s_d, s_dv});
                void'(hist.pop_back());
            end
            chk("mon_q", q, cur[8:1]);
            chk("mon_qv", qv, cur[0]);
            fcnt = 0;
            foreach (hist[k]) fcnt += int'(hist[k][0]);
            chk("mon_fill", fill, fcnt);
            sel = (int'(tap_sel) >= N) ? N - 1 : int'(tap_sel);
            h = hist[sel];
            chk("mon_tap", tap, h[8:1]);
            chk("mon_tapv", tapv, h[0]);
        end
    end

    initial begin : stim
        int r;
        logic [7:0] bub_d [6];
        logic       bub_v [6];
        bub_d = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        bub_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state at time zero.
        rstn = 1'b0; d = 8'hA5; dv = 1'b1; en = 1'b1;
        sb_reset();
        #1;
        chk("init_q", q, RV);
        chk("init_qv", qv, 0);
        chk("init_fill", fill, 0);
        @(negedge clk);
        rstn = 1'b1; en = 1'b0;

        // Run with A5 words, then reset asynchronously mid-stream.
        repeat (3) drive(1'b1, 1'b0, 8'hA5, 1'b1, 2'd0);
        reset_pulse();

        // Latency: Q=1 on the 4th enabled edge; FILL 1,2,3,4,4.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1, 2'd0);
            @(posedge clk);
            #3;
            chk("lat_fill", fill, (i < 4) ? i : 4);
            if (i >= 4) begin
                chk("lat_q", q, i - 3);
                chk("lat_qv", qv, 1);
            end
        end

        // Enable stall mid-stream.
        drive(1'b1, 1'b0, 8'd6, 1'b1, 2'd0);
        drive(1'b1, 1'b0, 8'd7, 1'b1, 2'd0);
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 1'b0, 8'($urandom), 1'b1, 2'd0);
            @(posedge clk);
            #3;
            chk("stall_q", q, 4);
            chk("stall_fill", fill, 4);
            chk("stall_tap", tap, 7);
        end
        drive(1'b1, 1'b0, 8'd8, 1'b1, 2'd0);
        drive(1'b1, 1'b0, 8'd9, 1'b1, 2'd0);
        drive(1'b1, 1'b0, 8'd10, 1'b1, 2'd0);
        @(posedge clk);
        #3;
        chk("stall_lat_q", q, 7);
        drive(1'b1, 1'b0, 8'd11, 1'b1, 2'd0);
        @(posedge clk);
        #3;
        chk("stall_next_q", q, 8);

        // Bubbles: QV pattern 1,0,1 at Q.
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 1'b0, bub_d[j], bub_v[j], 2'd0);
            @(posedge clk);
            #3;
            if (j >= 3) begin
                chk("bub_q", q, bub_d[j-3]);
                chk("bub_qv", qv, bub_v[j-3]);
            end
        end
        chk("bub_fill", fill, 1);

        // Clear with EN=0.
        drive(1'b0, 1'b1, 8'h5A, 1'b1, 2'd0);
        @(posedge clk);
        #3;
        chk("clr_fill", fill, 0);
        chk("clr_qv", qv, 0);
        chk("clr_q", q, RV);

        // Clear with EN=1 must clear rather than shift.
        drive(1'b1, 1'b0, 8'hA1, 1'b1, 2'd0);
        drive(1'b1, 1'b0, 8'hA2, 1'b1, 2'd0);
        drive(1'b1, 1'b0, 8'hA3, 1'b1, 2'd0);
        @(posedge clk);
        #3;
        chk("pre_clr_fill", fill, 3);
        drive(1'b1, 1'b1, 8'h77, 1'b1, 2'd0);
        @(posedge clk);
        #3;
        chk("clr_en_fill", fill, 0);
        chk("clr_en_q", q, RV);
        chk("clr_en_tap", tap, RV);
        chk("clr_en_tapv", tapv, 0);

        // Tap sweep with stages 4,3,2,1 (S[0]=4).
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 8'(i), 1'b1, 2'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            #0.5;
            tap_sel = 2'(k);
            tap_sel3 = 2'(k);
            #0.5;
            chk("tap_sweep", tap, 4 - k);
            chk("tap_sweep_v", tapv, 1);
            chk("tap3_sweep", tap3, (k < 3) ? 4 - k : 2);
        end

        // Randomized traffic with occasional clears and async resets.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) reset_pulse();
            else drive(r >= 30, r < 6, 8'($urandom), 1'($urandom), 2'($urandom));
        end

        // Legacy equivalence: D toggles every 1 ns, CLK period 8 ns.
        @(negedge clk);
        en = 1'b0;
        chk("leg_rst_q", q1, 0);
        rstn1 = 1'b1;
        for (int t = 0; t < 200; t++) begin
            d1 = 1'($urandom);
            #0.25;
            chk("leg_q", q1, sq);
            #0.75;
        end
        chk("leg_qv", qv1, 1);
        chk("leg_tap", tap1, sq);
        chk("leg_fill", fill1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
